// File: rtl/pad_display_ctrl.sv
// Pad display controller: 16 pad brightness levels lit by two arbitrated
// requesters, decayed once every DECAY_FRAMES frames, read back by a
// two-stage pixel pipeline for the color mapper.
module pad_display_ctrl #(
  parameter int unsigned X0           = 128,
  parameter int unsigned Y0           = 48,
  parameter int unsigned PITCH        = 96,
  parameter int unsigned PAD          = 88,
  parameter int unsigned DECAY_FRAMES = 4
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_tick,
  input  logic        clear_all,
  input  logic        key_req,
  input  logic [3:0]  key_pad,
  input  logic        seq_req,
  input  logic [3:0]  seq_pad,
  output logic        key_ack,
  output logic        seq_ack,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic        is_pad,
  output logic [3:0]  pad_level,
  output logic [3:0]  pad_idx,
  output logic [15:0] active_mask
);

  localparam int unsigned DCW = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;
  localparam int unsigned CW  = 11;
  localparam logic [DCW-1:0] DC_LAST = DCW'(DECAY_FRAMES - 1);

  logic [3:0]     r_level [16];
  logic [3:0]     w_level_nxt [16];
  logic [15:0]    w_mask_nxt;
  logic [DCW-1:0] r_dcnt;
  logic [DCW-1:0] w_dcnt_nxt;
  logic           r_last_seq;
  logic           w_key_elig;
  logic           w_seq_elig;
  logic           w_grant_key;
  logic           w_grant_seq;
  logic           w_grant_any;
  logic [3:0]     w_grant_pad;
  logic           w_wrap;

  logic [CW-1:0]  w_rx;
  logic [CW-1:0]  w_ry;
  logic [2:0]     w_ax;
  logic [2:0]     w_ay;
  logic           r_s1_on;
  logic [3:0]     r_s1_idx;

  // Per-axis pad lookup: returns {on_pad_axis, cell}; negative offsets wrap
  // above 4*PITCH as unsigned and are rejected by the bit-10 sign test.
  function automatic logic [2:0] axis_hit(input logic [CW-1:0] r);
    logic [1:0]    c;
    logic [CW-1:0] base;
    logic          on;
    if (r < CW'(PITCH)) begin
      c = 2'd0; base = '0;
    end else if (r < CW'(2 * PITCH)) begin
      c = 2'd1; base = CW'(PITCH);
    end else if (r < CW'(3 * PITCH)) begin
      c = 2'd2; base = CW'(2 * PITCH);
    end else begin
      c = 2'd3; base = CW'(3 * PITCH);
    end
    on = !r[CW-1] && (r < CW'(4 * PITCH)) && ((r - base) < CW'(PAD));
    return {on, c};
  endfunction

  // Arbitration, decay and next-level computation; clear_all overrides all.
  always_comb begin
    w_key_elig  = key_req & ~key_ack;
    w_seq_elig  = seq_req & ~seq_ack;
    w_grant_key = 1'b0;
    w_grant_seq = 1'b0;
    if (!clear_all) begin
      if (w_key_elig && w_seq_elig) begin
        w_grant_key = r_last_seq;
        w_grant_seq = ~r_last_seq;
      end else begin
        w_grant_key = w_key_elig;
        w_grant_seq = w_seq_elig;
      end
    end
    w_grant_any = w_grant_key | w_grant_seq;
    w_grant_pad = w_grant_key ? key_pad : seq_pad;
    w_wrap      = frame_tick && (r_dcnt == DC_LAST);

    w_dcnt_nxt = r_dcnt;
    if (clear_all) begin
      w_dcnt_nxt = '0;
    end else if (frame_tick) begin
      w_dcnt_nxt = w_wrap ? '0 : r_dcnt + DCW'(1);
    end

    w_mask_nxt = '0;
    for (int i = 0; i < 16; i++) begin
      w_level_nxt[i] = r_level[i];
      if (w_wrap && (r_level[i] != 4'd0)) w_level_nxt[i] = r_level[i] - 4'd1;
      if (w_grant_any && (w_grant_pad == 4'(i))) w_level_nxt[i] = 4'hF;
      if (clear_all) w_level_nxt[i] = 4'd0;
      w_mask_nxt[i] = (w_level_nxt[i] != 4'd0);
    end
  end

  // Pixel offsets relative to the grid origin (11-bit two's complement).
  always_comb begin
    w_rx = {1'b0, DrawX} - CW'(X0);
    w_ry = {1'b0, DrawY} - CW'(Y0);
    w_ax = axis_hit(w_rx);
    w_ay = axis_hit(w_ry);
  end

  // Level storage, decay counter, round-robin pointer and acknowledges.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 16; i++) r_level[i] <= 4'd0;
      r_dcnt      <= '0;
      r_last_seq  <= 1'b1;
      key_ack     <= 1'b0;
      seq_ack     <= 1'b0;
      active_mask <= '0;
    end else begin
      for (int i = 0; i < 16; i++) r_level[i] <= w_level_nxt[i];
      r_dcnt      <= w_dcnt_nxt;
      key_ack     <= w_grant_key;
      seq_ack     <= w_grant_seq;
      active_mask <= w_mask_nxt;
      if (w_grant_key) r_last_seq <= 1'b0;
      else if (w_grant_seq) r_last_seq <= 1'b1;
    end
  end

  // Two-stage pixel pipeline: geometry, then level lookup.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_s1_on   <= 1'b0;
      r_s1_idx  <= 4'd0;
      is_pad    <= 1'b0;
      pad_level <= 4'd0;
      pad_idx   <= 4'd0;
    end else begin
      r_s1_on   <= w_ax[2] & w_ay[2];
      r_s1_idx  <= {w_ay[1:0], w_ax[1:0]};
      is_pad    <= r_s1_on && (r_level[r_s1_idx] != 4'd0);
      pad_level <= r_s1_on ? r_level[r_s1_idx] : 4'd0;
      pad_idx   <= r_s1_on ? r_s1_idx : 4'd0;
    end
  end

endmodule

// File: tb/tb_pad_display_ctrl.sv
// Bench for pad_display_ctrl: integer reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_pad_display_ctrl;

  localparam int X0 = 128, Y0 = 48, PITCH = 96, PAD = 88, DF = 4;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b1;
  logic        frame_tick = 1'b0, clear_all = 1'b0;
  logic        key_req = 1'b0, seq_req = 1'b0;
  logic [3:0]  key_pad = 4'd0, seq_pad = 4'd0;
  logic        key_ack, seq_ack, is_pad;
  logic [9:0]  DrawX = 10'd0, DrawY = 10'd0;
  logic [3:0]  pad_level, pad_idx;
  logic [15:0] active_mask;

  int total = 0;
  int bad   = 0;

  pad_display_ctrl dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .clear_all(clear_all),
    .key_req(key_req), .key_pad(key_pad), .seq_req(seq_req), .seq_pad(seq_pad),
    .key_ack(key_ack), .seq_ack(seq_ack), .DrawX(DrawX), .DrawY(DrawY),
    .is_pad(is_pad), .pad_level(pad_level), .pad_idx(pad_idx),
    .active_mask(active_mask)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model state
  int m_lvl [16];
  int m_ticks;
  bit m_last_seq, m_kack, m_sack;
  bit m_s1_on, m_is;
  int m_s1_idx, m_plev, m_pidx;
  bit ke, se, gk, gs, wrap, g_on;
  int g_idx;

  // Pad geometry from division/modulo
  function automatic void geo(input int x, input int y, output bit on, output int idx);
    int rx, ry;
    rx = x - X0;
    ry = y - Y0;
    on = rx >= 0 && rx < 4 * PITCH && ry >= 0 && ry < 4 * PITCH &&
         (rx % PITCH) < PAD && (ry % PITCH) < PAD;
    idx = on ? (ry / PITCH) * 4 + rx / PITCH : 0;
  endfunction

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      foreach (m_lvl[i]) m_lvl[i] = 0;
      m_ticks = 0; m_last_seq = 1; m_kack = 0; m_sack = 0;
      m_s1_on = 0; m_s1_idx = 0; m_is = 0; m_plev = 0; m_pidx = 0;
    end else begin
      m_is   = m_s1_on && (m_lvl[m_s1_idx] != 0);
      m_plev = m_s1_on ? m_lvl[m_s1_idx] : 0;
      m_pidx = m_s1_on ? m_s1_idx : 0;
      geo(int'(DrawX), int'(DrawY), g_on, g_idx);
      m_s1_on = g_on; m_s1_idx = g_idx;
      ke = key_req && !m_kack;
      se = seq_req && !m_sack;
      gk = 0; gs = 0;
      if (!clear_all) begin
        if (ke && se) begin
          if (m_last_seq) gk = 1; else gs = 1;
        end else begin
          gk = ke; gs = se;
        end
      end
      m_kack = gk; m_sack = gs;
      if (gk) m_last_seq = 0;
      if (gs) m_last_seq = 1;
      if (clear_all) begin
        foreach (m_lvl[i]) m_lvl[i] = 0;
        m_ticks = 0;
      end else begin
        wrap = 0;
        if (frame_tick) begin
          m_ticks = (m_ticks + 1) % DF;
          wrap = (m_ticks == 0);
        end
        if (wrap) foreach (m_lvl[i]) if (m_lvl[i] > 0) m_lvl[i] = m_lvl[i] - 1;
        if (gk) m_lvl[key_pad] = 15;
        if (gs) m_lvl[seq_pad] = 15;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge Clk) begin
    logic [15:0] em;
    for (int i = 0; i < 16; i++) em[i] = (m_lvl[i] != 0);
    chk("key_ack", key_ack, m_kack);
    chk("seq_ack", seq_ack, m_sack);
    chk("active_mask", active_mask, em);
    chk("is_pad", is_pad, m_is);
    chk("pad_level", pad_level, m_plev);
    chk("pad_idx", pad_idx, m_pidx);
  end

  task automatic step();
    @(negedge Clk);
    #1;
  endtask

  task automatic light_key(input int p);
    bit got;
    got = 0;
    key_req = 1'b1;
    key_pad = 4'(p);
    for (int k = 0; k < 8 && !got; k++) begin
      step();
      got = key_ack;
    end
    key_req = 1'b0;
    total++;
    if (!got) begin
      bad++;
      $display("FAIL light_key: pad %0d got no ack, required ack within 8 cycles", p);
    end
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
  endtask

  task automatic clear1();
    clear_all = 1'b1;
    step();
    clear_all = 1'b0;
  endtask

  task automatic pix(input int x, input int y);
    DrawX = 10'(x);
    DrawY = 10'(y);
    step();
    step();
  endtask

  initial begin
    int kc, sc;
    #1 Reset_n = 1'b0;
    step(); step();
    chk("reset mask", active_mask, 16'h0000);
    chk("reset key_ack", key_ack, 0);
    chk("reset pad_level", pad_level, 0);
    Reset_n = 1'b1;
    step();

    // Both requesters at once: key first from reset pointer
    key_req = 1; key_pad = 4'd0; seq_req = 1; seq_pad = 4'd15;
    kc = -1; sc = -1;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (key_ack) begin kc = c; key_req = 0; end
      if (seq_ack) begin sc = c; seq_req = 0; end
    end
    key_req = 0; seq_req = 0;
    chk("conflict key cycle", kc, 1);
    chk("conflict seq cycle", sc, 2);
    chk("conflict mask", active_mask, 16'h8001);
    clear1();
    step();
    chk("clear mask", active_mask, 16'h0000);

    // Single key request to pad 5 plus pixel readout
    key_req = 1; key_pad = 4'd5; DrawX = 10'd234; DrawY = 10'd154;
    step();
    chk("single ack", key_ack, 1);
    chk("single mask", active_mask, 16'h0020);
    key_req = 0;
    step();
    chk("pad5 is_pad", is_pad, 1);
    chk("pad5 level", pad_level, 15);
    chk("pad5 idx", pad_idx, 5);

    // Decay of pad 3
    clear1();
    light_key(3);
    DrawX = 10'd426; DrawY = 10'd58;
    repeat (8) tick();
    chk("decay 8 ticks", pad_level, 13);
    repeat (52) tick();
    chk("decay 60 mask bit3", active_mask[3], 0);
    chk("decay 60 level", pad_level, 0);
    repeat (8) tick();
    chk("decay no underflow", pad_level, 0);

    // Grant coinciding with a decay wrap
    clear1();
    light_key(2);
    light_key(7);
    repeat (24) tick();
    repeat (3) tick();
    key_req = 1; key_pad = 4'd2; frame_tick = 1;
    step();
    frame_tick = 0; key_req = 0;
    chk("wrap grant ack", key_ack, 1);
    pix(330, 58);
    chk("wrap grant pad2", pad_level, 15);
    pix(426, 154);
    chk("wrap decay pad7", pad_level, 8);

    // clear_all with pending request
    clear_all = 1; key_req = 1; key_pad = 4'd9;
    step();
    chk("clear no ack", key_ack, 0);
    chk("clear zero mask", active_mask, 16'h0000);
    clear_all = 0;
    step();
    key_req = 0;
    chk("after clear ack", key_ack, 1);
    chk("after clear mask", active_mask, 16'h0200);

    // Gaps and outside with all pads lit
    for (int p = 0; p < 16; p++) light_key(p);
    pix(216, 60);
    chk("gap is_pad", is_pad, 0);
    chk("gap level", pad_level, 0);
    chk("gap idx", pad_idx, 0);
    pix(100, 60);
    chk("left is_pad", is_pad, 0);
    chk("left idx", pad_idx, 0);
    pix(215, 60);
    chk("edge on pad0", is_pad, 1);
    pix(128 + 3 * 96 + 87, 48 + 3 * 96 + 87);
    chk("corner pad15 idx", pad_idx, 15);
    pix(128 + 4 * 96, 60);
    chk("right edge out", is_pad, 0);
    begin
      int xs [6] = '{127, 128, 223, 224, 511, 600};
      int ys [6] = '{47, 48, 135, 144, 431, 432};
      for (int i = 0; i < 6; i++) begin
        DrawX = 10'(xs[i]);
        DrawY = 10'(ys[5 - i]);
        step();
      end
      step(); step();
    end

    // Reset during a pending request, then re-grant while still requested
    key_req = 1; key_pad = 4'd4; Reset_n = 0;
    step();
    chk("mid reset mask", active_mask, 16'h0000);
    chk("mid reset ack", key_ack, 0);
    Reset_n = 1;
    step();
    key_req = 0;
    chk("post reset grant", active_mask, 16'h0010);
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pad_display_ctrl.md
PAD_DISPLAY_CTRL -- requirements
Module: pad_display_ctrl

Interface
REQ-001 Parameter X0, default 128, left pixel column of the pad grid.
REQ-002 Parameter Y0, default 48, top pixel row of the pad grid.
REQ-003 Parameter PITCH, default 96, pad-to-pad spacing in pixels; PAD, default 88, lit pad width/height in pixels (PAD < PITCH).
REQ-004 Parameter DECAY_FRAMES, default 4, frame_ticks per one-step brightness decay (>=1).
REQ-005 Clk  in  1  system clock; all logic single clock domain.
REQ-006 Reset_n  in  1  asynchronous, active-low reset.
REQ-007 frame_tick  in  1  one-cycle pulse per frame (from the VGA timing block, already synchronous to Clk).
REQ-008 clear_all  in  1  synchronous level-sensitive clear of all pad brightness.
REQ-009 key_req  in  1 / key_pad  in  4  keyboard requester: light pad key_pad.
REQ-010 seq_req  in  1 / seq_pad  in  4  sequencer requester: light pad seq_pad.
REQ-011 key_ack  out  1 / seq_ack  out  1  registered one-cycle acknowledge per requester.
REQ-012 DrawX, DrawY  in  10 each  current pixel coordinates.
REQ-013 is_pad  out  1  pixel lies on a lit pad (level != 0), for the color mapper.
REQ-014 pad_level  out  4  brightness of that pad; pad_idx  out  4  pad index (row*4+col).
REQ-015 active_mask  out  16  bit i = (level[i] != 0), registered.

Function
REQ-016 Storage: 16 pads x 4-bit level, pad index = row*4 + col, row/col in 0..3.
REQ-017 Handshake: requester holds req and pad stable until ack; ack high exactly one cycle, the cycle after the grant edge; a requester whose ack is currently high is not eligible for a new grant.
REQ-018 Grant: at most one grant per cycle; granted pad's level set to 15 on the grant edge; ack asserted on that same edge.
REQ-019 Arbitration: if only one eligible requester, grant it; if both eligible, round-robin via a 1-bit last_grant pointer (reset value: seq, so key wins the first conflict), pointer updated on every grant.
REQ-020 Same pad requested by both: still two separate grants in consecutive cycles; level 15 either way.
REQ-021 Decay counter: 0..DECAY_FRAMES-1, increments on frame_tick, wraps to 0; on the wrap edge every nonzero level decrements by 1, saturating at 0.
REQ-022 Grant and decay on the same edge for the same pad: grant wins (level = 15); other pads decay normally.
REQ-023 clear_all high: all levels -> 0 and decay counter -> 0 on that edge; no grant and no ack in that cycle; requests stay pending and are granted after clear_all deasserts.
REQ-024 Pixel stage 1 (registered): rx = DrawX - X0, ry = DrawY - Y0 in 11-bit signed arithmetic; inside = 0 <= rx < 4*PITCH and 0 <= ry < 4*PITCH; col/row found by comparing rx/ry against PITCH, 2*PITCH, 3*PITCH (no divider); on_pad = inside and (rx - col*PITCH) < PAD and (ry - row*PITCH) < PAD.
REQ-025 Pixel stage 2 (registered): pad_idx = row*4+col; pad_level = on_pad ? level[pad_idx] : 0; is_pad = on_pad and level != 0.
REQ-026 Pixel latency exactly 2 Clk cycles from DrawX/DrawY to is_pad/pad_level/pad_idx; level used is the value at the stage-2 edge.
REQ-027 Outside grid or in a gap: is_pad = 0, pad_level = 0, pad_idx = 0.

Reset
REQ-028 Reset_n low asynchronously forces: all levels 0, decay counter 0, last_grant = seq, key_ack = seq_ack = 0, both pixel pipeline stages 0 (is_pad = 0, pad_level = 0, pad_idx = 0), active_mask = 0.
REQ-029 Reset asserted mid-handshake discards the request; no ack is issued after Reset_n releases unless req is still high, in which case it is granted as a new request.

Verification
REQ-030 key_req=1, key_pad=5 for one cycle with seq idle -> key_ack high next cycle; active_mask = 0x0020; DrawX=128+96+10, DrawY=48+96+10 -> 2 cycles later is_pad=1, pad_level=15, pad_idx=5.
REQ-031 key_req and seq_req both held (pads 0 and 15) -> key_ack cycle N+1, seq_ack cycle N+2; active_mask = 0x8001.
REQ-032 Pad 3 lit, DECAY_FRAMES=4, 8 frame_ticks -> level 13; after 60 ticks -> level 0, active_mask bit 3 = 0, no underflow after further ticks.
REQ-033 Grant to pad 2 on the same edge as a decay wrap, pad 2 previously 9 -> level 15; pad 7 previously 9 -> 8.
REQ-034 clear_all high while key_req pending -> all levels 0, no key_ack that cycle; clear_all low -> key_ack next cycle, level 15.
REQ-035 DrawX=128+88 (gap), DrawY=60 and DrawX=100 (left of grid) with all pads lit -> is_pad=0, pad_level=0, pad_idx=0.
